// File: rtl/peak_uart_tx.sv
// Serializes a captured 32-bit peak word as four UART bytes (channel 1 first) on txd.
// Define PEAK_UART_PARITY_EN for 8E1 framing (even parity bit after the data bits); default is 8N1.
module peak_uart_tx #(
  parameter int CLK_DIV = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] frame_in,
  input  logic        send,
  output logic        busy,
  output logic        done,
  output logic        txd
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  state_t      state, state_n;
  logic [15:0] baud_cnt, baud_n;
  logic [2:0]  bit_idx, bit_n;
  logic [1:0]  byte_idx, byte_n;
  logic [31:0] shadow, shadow_n;
  logic        txd_n, busy_n, done_n;
  logic [7:0]  cur_byte;
  logic [2:0]  bit_next;
  logic        bit_end;

  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign bit_next = bit_idx + 3'd1;

  always_comb begin
    cur_byte = shadow[31:24];
    case (byte_idx)
      2'd0: cur_byte = shadow[31:24];
      2'd1: cur_byte = shadow[23:16];
      2'd2: cur_byte = shadow[15:8];
      2'd3: cur_byte = shadow[7:0];
      default: cur_byte = shadow[31:24];
    endcase
  end

  // txd_n is the line level for the cycle after the edge, so txd itself stays a clean register output.
  always_comb begin
    state_n  = state;
    baud_n   = baud_cnt;
    bit_n    = bit_idx;
    byte_n   = byte_idx;
    shadow_n = shadow;
    txd_n    = txd;
    busy_n   = busy;
    done_n   = 1'b0;

    if (state != IDLE) begin
      baud_n = bit_end ? 16'd0 : baud_cnt + 16'd1;
    end

    case (state)
      IDLE: begin
        txd_n = 1'b1;
        if (send && !busy) begin
          shadow_n = frame_in;
          byte_n   = 2'd0;
          bit_n    = 3'd0;
          baud_n   = 16'd0;
          state_n  = START;
          txd_n    = 1'b0;
          busy_n   = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          bit_n   = 3'd0;
          txd_n   = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            bit_n = 3'd0;
`ifdef PEAK_UART_PARITY_EN
            state_n = PARITY;
            txd_n   = ^cur_byte;
`else
            state_n = STOP;
            txd_n   = 1'b1;
`endif
          end else begin
            bit_n = bit_next;
            txd_n = cur_byte[bit_next];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          txd_n   = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_idx == 2'd3) begin
            state_n = IDLE;
            txd_n   = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            byte_n  = byte_idx + 2'd1;
            state_n = START;
            txd_n   = 1'b0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      byte_idx <= 2'd0;
      shadow   <= 32'd0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      shadow   <= shadow_n;
      txd      <= txd_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_peak_uart_tx.sv
// Scoreboard bench for peak_uart_tx: expected bytes are queued when a frame is requested
// and popped by a UART line decoder; frame timing and handshake are checked directly.
module tb_peak_uart_tx;

  localparam int CLK_DIV = 4;
`ifdef PEAK_UART_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  localparam longint FRAME = 4 * BITS * CLK_DIV;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] frame_in = 32'd0;
  logic        send = 1'b0;
  logic        busy, done, txd;

  int          checks = 0;
  int          failures = 0;
  longint      cyc = 0;
  int          done_count = 0;
  bit          mon_en = 1'b0;
  logic        prev_txd = 1'b1;
  logic [7:0]  exp_q[$];

  peak_uart_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clock(clock),
    .reset(reset),
    .frame_in(frame_in),
    .send(send),
    .busy(busy),
    .done(done),
    .txd(txd)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) if (done === 1'b1) done_count <= done_count + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Request one frame; returns the cycle index of the first start-bit cycle.
  task automatic applyStimulus(input logic [31:0] word, input bit expect_bytes, input bit hold_send,
                               output longint start_cyc);
    @(negedge clock);
    frame_in = word;
    send = 1'b1;
    if (expect_bytes) begin
      exp_q.push_back(word[31:24]);
      exp_q.push_back(word[23:16]);
      exp_q.push_back(word[15:8]);
      exp_q.push_back(word[7:0]);
    end
    @(negedge clock);
    if (!hold_send) send = 1'b0;
    start_cyc = cyc;
    checkOutput("busy_after_send", busy, 1);
    checkOutput("start_bit_first_cycle", txd, 0);
  endtask

  task automatic wait_done(output longint at);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (done !== 1'b1 && n < 2000);
    at = cyc;
  endtask

  // UART decoder: samples each bit in the middle of its CLK_DIV-cycle window.
  initial begin
    logic [7:0] rx;
    logic [7:0] expb;
    forever begin
      @(negedge clock);
      if (mon_en && prev_txd === 1'b1 && txd === 1'b0) begin
        repeat (CLK_DIV / 2) @(negedge clock);
        checkOutput("start_bit", txd, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clock);
          rx[i] = txd;
        end
        checks++;
        assert (exp_q.size() > 0) else begin
          failures++;
          $error("[TB] FAIL unexpected_byte: observed=%0h expected=none", rx);
        end
        expb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        checkOutput("rx_byte", rx, expb);
`ifdef PEAK_UART_PARITY_EN
        repeat (CLK_DIV) @(negedge clock);
        checkOutput("parity_bit", txd, ^expb);
`endif
        repeat (CLK_DIV) @(negedge clock);
        checkOutput("stop_bit", txd, 1);
        prev_txd = 1'b1;
      end else begin
        prev_txd = txd;
      end
    end
  end

  initial begin
    longint s, d1, d2;
    int dc;

    // Reset state while the clock runs
    repeat (3) @(negedge clock);
    checkOutput("reset_txd", txd, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);

    // Abort a frame during its first start bit
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(32'hA53C00FF, 1'b0, 1'b0, s);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("abort_txd", txd, 1);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    dc = done_count;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (200) @(negedge clock);
    checkOutput("abort_no_done", done_count, dc);
    checkOutput("abort_stays_idle", busy, 0);
    checkOutput("abort_idle_txd", txd, 1);

    mon_en = 1'b1;

    // Single frame with frame_in changed one cycle after acceptance
    applyStimulus(32'hA53C00FF, 1'b1, 1'b0, s);
    @(negedge clock);
    frame_in = 32'h12345678;
    wait_done(d1);
    checkOutput("frame_len", 32'(d1 - s), 32'(FRAME));
    checkOutput("busy_low_at_done", busy, 0);
    @(negedge clock);
    checkOutput("done_one_cycle", done, 0);

    // send pulse during byte 2 must be ignored
    dc = done_count;
    applyStimulus(32'h11223344, 1'b1, 1'b0, s);
    repeat (BITS * CLK_DIV + 8) @(negedge clock);
    frame_in = 32'hDEADBEEF;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    wait_done(d1);
    checkOutput("busy_reject_len", 32'(d1 - s), 32'(FRAME));
    repeat (60) @(negedge clock);
    checkOutput("busy_reject_single_done", done_count, dc + 1);
    checkOutput("busy_reject_idle", busy, 0);

    // Back-to-back frames with send held high
    applyStimulus(32'hC0FFEE01, 1'b1, 1'b1, s);
    frame_in = 32'h5A6B7C8D;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h6B);
    exp_q.push_back(8'h7C);
    exp_q.push_back(8'h8D);
    wait_done(d1);
    checkOutput("b2b_first_len", 32'(d1 - s), 32'(FRAME));
    checkOutput("b2b_idle_txd", txd, 1);
    @(negedge clock);
    checkOutput("b2b_restart_busy", busy, 1);
    checkOutput("b2b_restart_txd", txd, 0);
    send = 1'b0;
    wait_done(d2);
    checkOutput("b2b_done_spacing", 32'(d2 - d1), 32'(FRAME + 1));
    repeat (50) @(negedge clock);
    checkOutput("b2b_no_third", busy, 0);

    // Parity-relevant pattern (parity bits 1,0,0,1 when enabled)
    applyStimulus(32'h01030080, 1'b1, 1'b0, s);
    wait_done(d1);
    checkOutput("parity_frame_len", 32'(d1 - s), 32'(FRAME));

    repeat (20) @(negedge clock);
    checkOutput("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/peak_uart_tx.md
# peak_uart_tx

Serial output stage for the peak-hold datapath. Captures the 32-bit `out_final` word (four 8-bit channel peaks) on request and transmits it as four consecutive UART bytes on a single `txd` line, channel 1 first. Sits directly downstream of the peak/final register stage and drives the board's UART TX pin.

## Interface

Parameters:
- `CLK_DIV`, default 434: clock cycles per UART bit (e.g. 50 MHz / 115200). Legal range 2..65535.

Ports:
- `clock`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `frame_in`  input  32  peak word; `[31:24]` = channel 1 … `[7:0]` = channel 4.
- `send`  input  1  transmit request; sampled every cycle.
- `busy`  output  1  high while a frame is in flight.
- `done`  output  1  one-cycle pulse when the frame's last stop bit completes.
- `txd`  output  1  UART serial line, idle high.

## Operation

- One clock, `clock`; asynchronous, active-low reset `reset`.
- Reset values: `txd`=1, `busy`=0, `done`=0, state IDLE, bit/byte/baud counters 0, shadow register 0.
- States: IDLE → START → DATA → (PARITY, only with macro) → STOP → IDLE or START.
- IDLE: `txd`=1. If `send`=1 and `busy`=0, latch `frame_in` into a 32-bit shadow register, clear byte index, go to START. `frame_in` changes after acceptance have no effect.
- START: `txd`=0 for `CLK_DIV` cycles.
- DATA: 8 bits of current byte, LSB first, each held `CLK_DIV` cycles.
- STOP: `txd`=1 for `CLK_DIV` cycles. If byte index < 3: increment index, go to START (no idle gap). If index = 3: go to IDLE, pulse `done`.
- Byte order: shadow `[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`.
- `send` while `busy`=1 is ignored (not queued).
- Baud counter counts 0..`CLK_DIV`-1, wraps at each bit boundary; bit index 0..7 wraps per byte; byte index 0..3.
- Reset asserted mid-frame: immediate abort, `txd` forced high, no `done`; new frame requires fresh `send` after reset release.

## Timing

- `send` accepted at edge N → `busy`=1 and `txd`=0 (start bit) from edge N+1.
- Each bit occupies exactly `CLK_DIV` cycles; `txd` is a registered output, glitch-free.
- Frame length: 4 × 10 × `CLK_DIV` cycles (4 × 11 × `CLK_DIV` with parity).
- At the edge ending the last stop bit: `busy` falls and `done`=1 for exactly one cycle, simultaneously.
- `send` high in the `done` cycle is accepted (busy already low); next start bit begins the following cycle, giving back-to-back frames with one idle-high cycle between.
- `send` held high continuously → frames repeat, each re-latching `frame_in` at acceptance.

## Configuration

- `PEAK_UART_PARITY_EN`: defined → PARITY state inserted after DATA, `txd` = even parity (XOR of 8 data bits) for `CLK_DIV` cycles; format 8E1, 11 bits/byte.
- Not defined → no PARITY state, format 8N1, 10 bits/byte.

## Test plan

- Reset: hold `reset`=0, toggle `clock` → `txd`=1, `busy`=0, `done`=0; assert `reset` low mid-byte → `txd`=1 within same cycle, `busy`=0, no `done`.
- Single frame, `CLK_DIV`=4, `frame_in`=32'hA5_3C_00_FF, one-cycle `send` → decoded bytes A5, 3C, 00, FF in order; 160 cycles from start-bit edge to `done`; `done` high one cycle.
- Latch isolation: change `frame_in` to 32'h12345678 one cycle after acceptance → transmitted bytes still A5, 3C, 00, FF.
- Busy rejection: pulse `send` during byte 2 → no extra frame; `busy` falls once, single `done`.
- Back-to-back: `send` held high, two different words → two complete frames, one idle cycle between, two `done` pulses 161 cycles apart (`CLK_DIV`=4).
- With `PEAK_UART_PARITY_EN`, `frame_in`=32'h01_03_00_80 → parity bits 1, 0, 0, 1; frame 176 cycles.
